// File: rtl/msi_mem_responder.sv
// Memory-side responder for a three-CPU MSI snooping bus: arbitrates fills and
// write-backs, broadcasts each read for one snoop cycle, serves or aborts it.

module msi_req_lane (
  input  logic       valid,
  input  logic [1:0] op,
  output logic       rd,
  output logic       wr
);
  assign rd = valid && (op == 2'b01);
  assign wr = valid && (op == 2'b10);
endmodule

module msi_mem_responder #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 3
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [2:0]            req_valid,
  input  logic [5:0]            req_op,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_data,
  input  logic                  snoop_supply,
  output logic                  snoop_valid,
  output logic [ADDR_W-1:0]     snoop_addr,
  output logic [1:0]            snoop_id,
  output logic [2:0]            ack,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_abort
);
  localparam int NUM_LANES = 3;
  localparam int DEPTH     = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, SNOOP, WRITE, RESP} state_t;

  typedef struct packed {
    logic [1:0]        id;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  state_t                                state;
  req_t                                  cur;
  logic [1:0]                            last_grant;
  logic [DATA_W-1:0]                     mem [DEPTH];
  logic [NUM_LANES-1:0]                  rd_v, wr_v, cls;
  logic [NUM_LANES-1:0][ADDR_W-1:0]      addr_v;
  logic [NUM_LANES-1:0][DATA_W-1:0]      data_v;
  logic [1:0]                            win_id;
  logic                                  win_vld, win_wr;

  assign addr_v = req_addr;
  assign data_v = req_data;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    msi_req_lane u_lane (
      .valid (req_valid[k]),
      .op    (req_op[2*k +: 2]),
      .rd    (rd_v[k]),
      .wr    (wr_v[k])
    );
  end

  // Write-backs outrank reads; within the winning class, round-robin from
  // last_grant+1. Scanning farthest-first lets the nearest candidate win.
  always_comb begin
    win_wr  = |wr_v;
    cls     = win_wr ? wr_v : rd_v;
    win_vld = |cls;
    win_id  = last_grant;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      int idx;
      idx = (int'(last_grant) + 1 + i) % NUM_LANES;
      if (cls[idx]) win_id = 2'(idx);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cur         <= '0;
      last_grant  <= 2'd2;
      snoop_valid <= 1'b0;
      snoop_addr  <= '0;
      snoop_id    <= '0;
      ack         <= '0;
      rsp_data    <= '0;
      rsp_abort   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            cur.id     <= win_id;
            cur.addr   <= addr_v[win_id];
            cur.data   <= data_v[win_id];
            last_grant <= win_id;
            if (win_wr) begin
              state <= WRITE;
            end else begin
              state       <= SNOOP;
              snoop_valid <= 1'b1;
              snoop_addr  <= addr_v[win_id];
              snoop_id    <= win_id;
            end
          end
        end
        SNOOP: begin
          snoop_valid <= 1'b0;
          // A supplying peer owns the block, so memory is left untouched.
          if (snoop_supply) rsp_abort <= 1'b1;
          else              rsp_data  <= mem[cur.addr];
          ack   <= 3'b001 << cur.id;
          state <= RESP;
        end
        WRITE: begin
          mem[cur.addr] <= cur.data;
          ack           <= 3'b001 << cur.id;
          state         <= RESP;
        end
        RESP: begin
          rsp_data  <= '0;
          rsp_abort <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_msi_mem_responder.sv
// Directed bench for msi_mem_responder: arbitration order, snoop abort,
// write-then-read ordering, round-robin rotation and mid-write reset.
module tb_msi_mem_responder;
  localparam int AW = 3;
  localparam int DW = 3;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    req_valid = '0;
  logic [5:0]    req_op = '0;
  logic [3*AW-1:0] req_addr = '0;
  logic [3*DW-1:0] req_data = '0;
  logic          snoop_supply = 1'b0;
  logic          snoop_valid;
  logic [AW-1:0] snoop_addr;
  logic [1:0]    snoop_id;
  logic [2:0]    ack;
  logic [DW-1:0] rsp_data;
  logic          rsp_abort;

  msi_mem_responder #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .snoop_supply (snoop_supply),
    .snoop_valid  (snoop_valid),
    .snoop_addr   (snoop_addr),
    .snoop_id     (snoop_id),
    .ack          (ack),
    .rsp_data     (rsp_data),
    .rsp_abort    (rsp_abort)
  );

  always #5 clock = ~clock;

  int   checks = 0;
  int   errors = 0;
  logic sup = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int k, input logic [1:0] op, input logic [2:0] a, input logic [2:0] d);
    req_valid[k]     = 1'b1;
    req_op[2*k +: 2] = op;
    req_addr[3*k +: 3] = a;
    req_data[3*k +: 3] = d;
  endtask

  task automatic clr_req(input int k);
    req_valid[k] = 1'b0;
  endtask

  // Steps until an ack appears (bounded); drives snoop_supply from sup while snooping.
  task automatic wait_ack(output logic [2:0] a, output logic [2:0] d, output logic ab, output int cyc);
    a = '0; d = '0; ab = 1'b0; cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      step;
      snoop_supply = snoop_valid & sup;
      if (ack != 3'b000) begin
        a = ack; d = rsp_data; ab = rsp_abort; cyc = i;
        break;
      end
    end
    snoop_supply = 1'b0;
    if (cyc == 0) chk("ack_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] a, d;
    logic       ab;
    int         cyc;
    logic [2:0] acc;
    logic [2:0] seq [4];
    int         at  [4];
    int         n;

    step; step;
    chk("rst_snoop_valid", snoop_valid, 0);
    chk("rst_snoop_addr", snoop_addr, 0);
    chk("rst_snoop_id", snoop_id, 0);
    chk("rst_ack", ack, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_abort", rsp_abort, 0);
    reset_n = 1'b1;
    step;

    // CPU1 read fill of addr 5, cycle by cycle
    set_req(1, 2'b01, 3'd5, 3'd0);
    step;
    chk("t1_snoop_valid", snoop_valid, 1);
    chk("t1_snoop_addr", snoop_addr, 5);
    chk("t1_snoop_id", snoop_id, 1);
    chk("t1_no_early_ack", ack, 0);
    step;
    chk("t1_ack", ack, 3'b010);
    chk("t1_rsp_data", rsp_data, 0);
    chk("t1_rsp_abort", rsp_abort, 0);
    chk("t1_snoop_drop", snoop_valid, 0);
    clr_req(1);
    step;
    chk("t1_ack_pulse", ack, 0);

    // CPU0 write-back then CPU2 read of the same address
    set_req(0, 2'b10, 3'd2, 3'd6);
    wait_ack(a, d, ab, cyc);
    chk("t2_wb_ack", a, 3'b001);
    chk("t2_wb_latency", cyc, 2);
    clr_req(0); step;
    set_req(2, 2'b01, 3'd2, 3'd0);
    wait_ack(a, d, ab, cyc);
    chk("t2_rd_ack", a, 3'b100);
    chk("t2_rd_data", d, 6);
    chk("t2_rd_latency", cyc, 2);
    clr_req(2); step;

    // Simultaneous read (CPU0) and write-back (CPU1) to addr 3
    set_req(0, 2'b01, 3'd3, 3'd0);
    set_req(1, 2'b10, 3'd3, 3'd7);
    wait_ack(a, d, ab, cyc);
    chk("t3_first_ack", a, 3'b010);
    clr_req(1);
    wait_ack(a, d, ab, cyc);
    chk("t3_second_ack", a, 3'b001);
    chk("t3_rd_data", d, 7);
    clr_req(0); step;
    chk("t3_idle_data", rsp_data, 0);
    chk("t3_idle_abort", rsp_abort, 0);

    // Peer supply aborts the memory read of addr 4
    set_req(2, 2'b10, 3'd4, 3'd3);
    wait_ack(a, d, ab, cyc);
    chk("t4_wb_ack", a, 3'b100);
    clr_req(2); step;
    set_req(2, 2'b01, 3'd4, 3'd0);
    sup = 1'b1;
    wait_ack(a, d, ab, cyc);
    sup = 1'b0;
    chk("t4_abort_ack", a, 3'b100);
    chk("t4_abort_flag", ab, 1);
    chk("t4_abort_data", d, 0);
    clr_req(2); step;
    chk("t4_idle_abort", rsp_abort, 0);
    set_req(2, 2'b01, 3'd4, 3'd0);
    wait_ack(a, d, ab, cyc);
    chk("t4_reread_data", d, 3);
    chk("t4_reread_abort", ab, 0);
    clr_req(2); step;

    // Ignored ops never acked; supply outside SNOOP is ignored
    set_req(0, 2'b11, 3'd1, 3'd1);
    set_req(1, 2'b00, 3'd1, 3'd1);
    snoop_supply = 1'b1;
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      step;
      acc = acc | ack;
    end
    snoop_supply = 1'b0;
    chk("ignored_ops_ack", acc, 0);
    chk("ignored_abort", rsp_abort, 0);
    clr_req(0); clr_req(1);

    // Continuous reads from all CPUs straight out of reset
    reset_n = 1'b0;
    set_req(0, 2'b01, 3'd0, 3'd0);
    set_req(1, 2'b01, 3'd1, 3'd0);
    set_req(2, 2'b01, 3'd7, 3'd0);
    step;
    reset_n = 1'b1;
    n = 0;
    for (int i = 1; i <= 30 && n < 4; i++) begin
      step;
      if (ack != 3'b000) begin
        seq[n] = ack; at[n] = i; n++;
      end
    end
    chk("rr_count", n, 4);
    chk("rr_ack0", seq[0], 3'b001);
    chk("rr_ack1", seq[1], 3'b010);
    chk("rr_ack2", seq[2], 3'b100);
    chk("rr_ack3", seq[3], 3'b001);
    chk("rr_first_latency", at[0], 2);
    chk("rr_gap1", at[1] - at[0], 3);
    chk("rr_gap2", at[2] - at[1], 3);
    chk("rr_gap3", at[3] - at[2], 3);
    clr_req(0); clr_req(1); clr_req(2);
    step; step; step;

    // Write addr 1 so the next reset has something to clear
    set_req(0, 2'b10, 3'd1, 3'd7);
    wait_ack(a, d, ab, cyc);
    chk("t6_pre_wb_ack", a, 3'b001);
    clr_req(0); step;

    // CPU1 write-back interrupted by reset during WRITE
    set_req(1, 2'b10, 3'd6, 3'd5);
    step;
    reset_n = 1'b0;
    #1;
    chk("t6_reset_ack", ack, 0);
    reset_n = 1'b1;
    wait_ack(a, d, ab, cyc);
    chk("t6_retry_ack", a, 3'b010);
    chk("t6_retry_latency", cyc, 2);
    clr_req(1); step;
    set_req(0, 2'b01, 3'd6, 3'd0);
    wait_ack(a, d, ab, cyc);
    chk("t6_mem6", d, 5);
    clr_req(0); step;
    set_req(0, 2'b01, 3'd1, 3'd0);
    wait_ack(a, d, ab, cyc);
    chk("t6_mem1_cleared", d, 0);
    clr_req(0); step;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/msi_mem_responder.md
# msi_mem_responder

Memory-side responder for the three-CPU MSI snooping bus: arbitrates read-fill and write-back requests from the caches, broadcasts each read to the other caches for one snoop cycle, and either returns data from the 8-entry shared memory or aborts the memory read when a peer cache supplies the block. It replaces the unarbitrated flag-priority shared memory and sits between the cache controllers and the storage array.

## Interface
- ADDR_W, 3, address width; memory depth is 2**ADDR_W.
- DATA_W, 3, data width.
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  3  per-CPU request; bit k is CPU k; held until that CPU's ack.
- req_op  in  6  per-CPU op, 2 bits each at [2k+1:2k]: 01 read fill, 10 write-back; 00 and 11 are ignored.
- req_addr  in  3*ADDR_W  per-CPU address, CPU k at [ADDR_W*k +: ADDR_W].
- req_data  in  3*DATA_W  per-CPU write-back data, same packing.
- snoop_supply  in  1  a peer cache owns the snooped block and supplies it; sampled in SNOOP.
- snoop_valid  out  1  snoop broadcast active; high only in SNOOP.
- snoop_addr  out  ADDR_W  address being snooped.
- snoop_id  out  2  requesting CPU; peers with this id ignore the snoop.
- ack  out  3  one-hot, one-cycle completion pulse to the served CPU.
- rsp_data  out  DATA_W  read data; valid with the ack of a read fill when rsp_abort=0.
- rsp_abort  out  1  with the ack: memory read aborted, data comes from the peer cache.

## Operation
- Memory: 2**ADDR_W x DATA_W array. Reset clears every word to 0.
- States: IDLE, SNOOP, WRITE, RESP.
- IDLE: a request is eligible when req_valid[k]=1 and req_op is 01 or 10.
  - Write-backs win over reads.
  - Within a class, selection is round-robin starting at last_grant+1 mod 3.
  - The winner's id, op, addr and data are latched. last_grant is updated to the winner.
  - Next state is SNOOP for a read and WRITE for a write-back.
- SNOOP: snoop_valid=1, with snoop_addr and snoop_id set from the latched request.
  - snoop_supply=1: set rsp_abort, leave memory unread and unwritten.
  - snoop_supply=0: load rsp_data from mem[addr].
  - Next state is RESP.
- WRITE: mem[addr] <= data. Next state is RESP.
- RESP: ack[id]=1 for exactly this cycle. rsp_data and rsp_abort hold their values. Next state is IDLE.
- The requester must drop req_valid or change the request on the cycle after ack. If the same request is still present, it is treated as a new request.
- Requests that change while not granted are sampled as they are at the next IDLE.
- Ignored ops (00, 11) never get an ack.

## Timing
- Reset values: state IDLE, last_grant=2 (so CPU 0 has first priority), snoop_valid=0, snoop_addr=0, snoop_id=0, ack=0, rsp_data=0, rsp_abort=0, memory all 0.
- Read fill: request seen at edge t0, SNOOP in cycle t0..t1, ack and data in cycle t1..t2. Latency is 2 cycles.
- Write-back: WRITE in cycle t0..t1, memory updated at t1, ack in cycle t1..t2. Latency is 2 cycles.
- Throughput is one transaction per 3 cycles, because RESP returns to IDLE.
- Write-back and read to the same address pending together: the write-back is served first, so the read returns the new data. This is the required ordering.
- rsp_abort and rsp_data are cleared when leaving RESP, so both outputs are 0 in IDLE.
- Reset asserted mid-transaction: the transaction is dropped with no ack, and a write in flight is discarded. The requester keeps req_valid and is re-served after reset.
- snoop_supply outside SNOOP is ignored.

## Test plan
- Reset, then CPU1 reads addr 5 with snoop_supply=0 -> snoop_valid=1 with snoop_addr=5, snoop_id=1 on cycle 1; on cycle 2 ack=3'b010, rsp_data=0, rsp_abort=0.
- CPU0 writes back addr 2, data 6, then CPU2 reads addr 2 -> two acks in order 001 then 100; CPU2 gets rsp_data=6.
- CPU0 reads addr 3 and CPU1 writes back addr 3, data 7, in the same cycle -> CPU1 is acked first; CPU0 then gets rsp_data=7.
- CPU2 reads addr 4 with snoop_supply=1 during SNOOP -> ack=100, rsp_abort=1, mem[4] unchanged; a later read with no supply returns the old value.
- All three CPUs hold continuous reads from reset -> acks rotate 001, 010, 100, 001, with one ack every 3 cycles.
- CPU1 write-back addr 6, data 5, with reset_n pulsed low during WRITE -> no ack, mem[6]=0 after reset; the held request then completes and mem[6]=5.
